// File: rtl/frame_reader.sv
// frame_reader: streams a stored frame out of the frame RAM once the write side
// reports the frame complete. A 2-entry skid FIFO absorbs the one-cycle RAM
// read latency. Reads are issued only while the FIFO plus the read in flight
// has room, so words stream back-to-back when downstream is always ready.
module frame_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              cleared,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE, REARM} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              inflight;       // read issued last cycle, data on rd_data now
  logic              inflight_last;  // that read was address DEPTH-1

  // FIFO head drives the stream outputs; tail is the second slot
  logic [DATA_W-1:0] h_data, t_data;
  logic              h_vld, t_vld, h_last, t_last;

  logic       pop;
  logic [2:0] occ;
  logic       issue;

  // words buffered or on their way, and whether one more read fits
  assign pop   = h_vld & out_ready;
  assign occ   = {2'b0, h_vld} + {2'b0, t_vld} + {2'b0, inflight};
  assign issue = (state == READ) && (occ < (3'd2 + {2'b0, pop}));

  assign rd_en     = issue;
  assign rd_addr   = ptr;
  assign out_data  = h_data;
  assign out_valid = h_vld;
  assign out_last  = h_last;
  assign cleared   = (state == DONE);
  assign busy      = (state != IDLE);

  // Frame sequencing: arm on start, walk the address range, drain, pulse, rearm
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (issue) begin
            if (ptr == LAST_ADDR) state <= DRAIN;
            else                  ptr   <= ptr + 1'b1;
          end
        end
        DRAIN: begin
          // nothing buffered or in flight after this cycle's transfer
          if (occ == {2'b0, pop}) state <= DONE;
        end
        DONE: begin
          ptr   <= '0;
          state <= REARM;
        end
        REARM: begin
          // a start left high from this frame must not start another
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the read whose data appears on rd_data next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (ptr == LAST_ADDR);
    end
  end

  // Two-slot FIFO: capture rd_data the cycle it is valid, advance on transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      h_data <= '0;
      h_last <= 1'b0;
      h_vld  <= 1'b0;
      t_data <= '0;
      t_last <= 1'b0;
      t_vld  <= 1'b0;
    end else if (pop) begin
      if (t_vld) begin
        h_data <= t_data;
        h_last <= t_last;
        if (inflight) begin
          t_data <= rd_data;
          t_last <= inflight_last;
        end else begin
          t_vld <= 1'b0;
        end
      end else if (inflight) begin
        h_data <= rd_data;
        h_last <= inflight_last;
      end else begin
        h_vld <= 1'b0;
      end
    end else if (inflight) begin
      // the issue rule guarantees a free slot here
      if (!h_vld) begin
        h_data <= rd_data;
        h_last <= inflight_last;
        h_vld  <= 1'b1;
      end else begin
        t_data <= rd_data;
        t_last <= inflight_last;
        t_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: random and directed frames through an 8-word reader plus
// one full-size frame through a default-size reader, both compared against
// the expected frame contents, ordering, handshake and timing rules.
module tb_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       rd_en, out_valid, out_last, cleared, busy;
  logic [2:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic [7:0] out_data;

  logic        k_start = 1'b0;
  logic        k_rd_en, k_out_valid, k_out_last, k_cleared, k_busy;
  logic [10:0] k_rd_addr;
  logic [7:0]  k_rd_data = '0;
  logic [7:0]  k_out_data;

  frame_reader #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .cleared(cleared), .busy(busy)
  );

  frame_reader dut_k (
    .clk(clk), .reset(reset), .start(k_start), .rd_en(k_rd_en), .rd_addr(k_rd_addr),
    .rd_data(k_rd_data), .out_data(k_out_data), .out_valid(k_out_valid),
    .out_ready(1'b1), .out_last(k_out_last), .cleared(k_cleared), .busy(k_busy)
  );

  // frame RAM models: one cycle read latency
  logic [7:0] mem8 [8];
  always @(posedge clk) begin
    if (rd_en)   rd_data   <= mem8[rd_addr];
    if (k_rd_en) k_rd_data <= k_rd_addr[7:0] ^ 8'h5A;
  end

  int checks = 0, errors = 0;
  int cyc = 0;
  int issued, accepted, clr_n, first_rd, first_vld, last_cyc, clr_cyc, busy_last;
  logic       stall_prev;
  logic [9:0] prev;
  int k_acc = 0, k_last = -1, k_clr = -1, k_clrn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    issued = 0; accepted = 0; clr_n = 0;
    first_rd = -1; first_vld = -1; last_cyc = -1; clr_cyc = -1; busy_last = -1;
    stall_prev = 1'b0; prev = '0;
  endtask

  // reference: frame words in address order, at most 2 reads ahead of the consumer
  task automatic mon();
    logic p;
    p = out_valid && out_ready;
    if (rd_en) begin
      check("rd_addr_order", 32'(rd_addr), 32'(issued));
      check("outstanding_le2", 32'((issued - accepted + 1 - int'(p)) <= 2), 32'd1);
      if (first_rd < 0) first_rd = cyc;
      issued++;
    end
    if (stall_prev) check("hold_stable", 32'({out_valid, out_last, out_data}), 32'(prev));
    if (out_valid && first_vld < 0) first_vld = cyc;
    if (p) begin
      if (accepted < 8) begin
        check("data", 32'(out_data), 32'(mem8[accepted]));
        check("last_flag", 32'(out_last), 32'(accepted == 7));
      end else begin
        check("extra_word", 32'(accepted), 32'd7);
      end
      if (out_last) last_cyc = cyc;
      accepted++;
    end
    stall_prev = out_valid && !out_ready;
    prev = {out_valid, out_last, out_data};
    if (cleared) begin
      clr_n++;
      clr_cyc = cyc;
      check("cleared_after_frame", 32'(accepted), 32'd8);
    end
    if (busy) busy_last = cyc;
    if (k_out_valid) begin
      check("k_data", 32'(k_out_data), 32'(8'(k_acc) ^ 8'h5A));
      if (k_out_last) begin
        k_last = cyc;
        check("k_last_idx", 32'(k_acc), 32'd2047);
      end
      k_acc++;
    end
    if (k_cleared) begin
      k_clrn++;
      k_clr = cyc;
    end
  endtask

  task automatic step(input logic rdy, input logic st, input logic rst, input logic kst = 1'b0);
    @(posedge clk);
    #1;
    out_ready = rdy; start = st; reset = rst; k_start = kst;
    cyc++;
    @(negedge clk);
    mon();
  endtask

  // mode 0: ready=1, 1: ready 1,0,0,1..., 2: ready 0 for 20 cycles, 3: random
  task automatic frame(input int mode, input int hold);
    int s;
    bit done;
    logic r;
    s = 0;
    for (int i = 0; i < 8; i++) mem8[i] = (mode == 0) ? 8'(i + 16) : 8'($urandom);
    clear_mon();
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      case (mode)
        0: r = 1'b1;
        1: r = (k % 4 == 0) || (k % 4 == 3);
        2: r = (k >= 20);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      step(r, k < hold, 1'b0);
      if (k == 0) s = cyc;
      if (mode == 2 && k == 19) check("stall_two_reads", 32'(issued), 32'd2);
      if (clr_n > 0 && !busy && k >= hold) done = 1;
    end
    check("frame_done_in_time", 32'(done), 32'd1);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    check("words", 32'(accepted), 32'd8);
    check("reads", 32'(issued), 32'd8);
    check("cleared_once", 32'(clr_n), 32'd1);
    if (mode == 0 && hold == 1) begin
      check("lat_first_rd", 32'(first_rd), 32'(s + 1));
      check("lat_first_vld", 32'(first_vld), 32'(s + 3));
      check("last_cycle", 32'(last_cyc), 32'(s + 10));
      check("cleared_cycle", 32'(clr_cyc), 32'(s + 11));
      check("busy_end", 32'(busy_last), 32'(s + 12));
    end
  endtask

  initial begin
    int s;
    clear_mon();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("reset_outputs", 32'({rd_en, rd_addr, out_valid, out_last, out_data, cleared, busy}), 32'd0);
    check("reset_outputs_k", 32'({k_rd_en, k_rd_addr, k_out_valid, k_out_last, k_out_data, k_cleared, k_busy}), 32'd0);

    frame(0, 1);    // directed timing frame
    frame(1, 1);    // ready 1,0,0,1
    frame(2, 1);    // ready held low then released
    frame(0, 40);   // start held long: one frame only
    frame(0, 1);    // second frame identical after start dropped
    for (int n = 0; n < 4; n++) frame(3, 1 + int'($urandom_range(0, 30)));

    // reset mid-frame after word 3
    for (int i = 0; i < 8; i++) mem8[i] = 8'(i + 16);
    clear_mon();
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 50 && accepted < 4; k++) step(1'b1, 1'b0, 1'b0);
    check("rst_word3_reached", 32'(accepted), 32'd4);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("rst_mid_outputs", 32'({rd_en, rd_addr, out_valid, out_last, out_data, cleared, busy}), 32'd0);
    check("rst_no_clear", 32'(clr_n), 32'd0);
    frame(0, 1);
    // reset with start high, then start stays high: accepted without a low
    step(1'b1, 1'b1, 1'b1);
    frame(0, 1);

    // full-size frame
    k_acc = 0; k_clrn = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    s = cyc;
    for (int k = 0; k < 2200 && k_clrn == 0; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("k_words", 32'(k_acc), 32'd2048);
    check("k_last_cycle", 32'(k_last), 32'(s + 2050));
    check("k_cleared_cycle", 32'(k_clr), 32'(s + 2051));
    check("k_cleared_once", 32'(k_clrn), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each stored word and of the output stream.
REQ-002 SHALL have parameter ADDR_W, default 11, read-address width.
REQ-003 SHALL have parameter DEPTH, default 2048, words per frame (addresses 0..DEPTH-1); DEPTH <= 2**ADDR_W, DEPTH >= 2.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  level request from the write-side settle counter: stored frame complete, begin readout.
REQ-007 SHALL have port rd_en  output  1  frame RAM read strobe.
REQ-008 SHALL have port rd_addr  output  ADDR_W  frame RAM read address.
REQ-009 SHALL have port rd_data  input  DATA_W  frame RAM read data, valid exactly 1 cycle after the rd_en cycle.
REQ-010 SHALL have port out_data  output  DATA_W  stream word.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-013 SHALL have port out_last  output  1  high with the word read from address DEPTH-1.
REQ-014 SHALL have port cleared  output  1  one-cycle pulse: frame fully delivered; drives the settle counter's cleared input.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN, DONE, REARM.
REQ-017 IDLE: start sampled 1 -> READ with read pointer = 0; otherwise stay.
REQ-018 READ: SHALL assert rd_en with rd_addr = pointer only when fifo_count + inflight - pop < 2 (pop = out_valid && out_ready, inflight = rd_en of previous cycle); pointer increments per issued read.
REQ-019 READ: issuing the read of address DEPTH-1 -> DRAIN; no read SHALL ever be issued outside READ or beyond DEPTH-1.
REQ-020 rd_data SHALL be captured into a 2-entry FIFO in the cycle it is valid; FIFO head drives out_data/out_valid/out_last directly from registers.
REQ-021 Word order SHALL be address 0 first, ascending; no word dropped or duplicated under any out_ready pattern.
REQ-022 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-023 DRAIN: FIFO empty and inflight = 0 -> DONE.
REQ-024 DONE: cleared = 1 for exactly this one cycle -> REARM.
REQ-025 REARM: stay until start sampled 0, then -> IDLE; a start held high never triggers a second readout.
REQ-026 Latency: start sampled in cycle c -> rd_en/rd_addr=0 in c+1 -> out_valid with word 0 in c+3.
REQ-027 Throughput: with out_ready held 1, one word per cycle, no bubbles between word 0 and word DEPTH-1.
REQ-028 start changes during READ/DRAIN/DONE SHALL be ignored.
REQ-029 Pointer width arithmetic: pointer compare against DEPTH-1 at ADDR_W bits; no wrap to 0 inside a frame.

Reset
REQ-030 reset SHALL force state IDLE, pointer 0, FIFO empty, inflight 0; outputs rd_en=0, rd_addr=0, out_valid=0, out_last=0, out_data=0, cleared=0, busy=0.
REQ-031 reset SHALL take priority over every other event, including mid-frame and during the DONE cycle (no cleared pulse emitted).
REQ-032 After reset the block SHALL be in IDLE and accept the next start high without requiring a low first.

Verification
REQ-033 DEPTH=8, RAM mem[i]=i+16, out_ready=1, start high cycle 5 -> rd_en cycles 6..13, out_data 16..23 cycles 8..15, out_last only cycle 15, cleared cycle 16, busy 6..17 (REARM until start low).
REQ-034 DEPTH=8, out_ready toggles 1,0,0,1 repeating -> stream 16..23 in order, no duplicates, out_data stable while stalled, never more than 2 reads outstanding+buffered.
REQ-035 DEPTH=8, out_ready=0 from start -> exactly 2 rd_en pulses (addr 0,1) then rd_en stays 0; release ready -> remaining 6 words delivered, cleared once.
REQ-036 start held 1 for 40 cycles, DEPTH=8 -> exactly one frame, one cleared pulse; start low then high -> second frame identical.
REQ-037 reset asserted after word 3 accepted -> next cycle all outputs 0, state IDLE; new start -> frame restarts at address 0, 8 words, one cleared.
REQ-038 Default DEPTH=2048, out_ready=1, start at cycle c -> 2048 words, out_last at c+2050, cleared at c+2051.
